gpca_mul_seq: RTL and testbench

- Sequential radix-2 shift-add multiplier/squarer: the inverse operation of the combinational divide/square-root cellular array.
- Shares that array's mode convention: X=1 selects the two-operand operation (here multiply); X=0 selects the single-operand root-family operation (here square).
- Used to reconstruct dividends/radicands from array results for self-check, and as a low-area product unit.
- Valid/ready handshake on both input and output sides.

---
 rtl/gpca_mul_seq.sv | 134 +++++++++++++
 tb/tb_gpca_mul_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpca_mul_seq.sv
// gpca_mul_seq: sequential radix-2 shift-add multiplier / squarer.
// Companion of the divide / square-root cellular array, sharing its mode bit:
// X=1 multiplies A*B, and X=0 squares A (B ignored). Both the input and output
// sides use a valid/ready handshake. A result appears exactly W edges after accept.
// Optional build macro: GPCA_MUL_SIGNED_EN treats A and B as two's complement.
module gpca_mul_seq #(
    parameter int W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             X,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [2*W-1:0]   S,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [2*W-1:0]  r_acc;
    logic [W-1:0]    r_mcand;
    logic [W-1:0]    r_mplier;
    logic [CW-1:0]   r_count;
    logic [2*W-1:0]  r_S;

    logic            w_accept;
    logic            w_lastStep;
    logic [W-1:0]    w_loadMcand;
    logic [W-1:0]    w_loadMplier;
    logic [2*W-1:0]  w_shifted;
    logic [2*W-1:0]  w_accNext;
    logic [2*W-1:0]  w_result;

    assign w_accept   = (r_state == IDLE) && in_valid;
    assign w_lastStep = (r_state == RUN) && (r_count == CW'(W - 1));

    // The mode bit only matters at accept. It selects what is loaded into the
    // multiplier, so nothing about the mode needs to be carried through RUN.
`ifdef GPCA_MUL_SIGNED_EN
    logic            r_neg;
    logic [W-1:0]    w_absA;
    logic [W-1:0]    w_absB;
    logic            w_loadNeg;

    // The magnitude of the most negative value is 2^(W-1), which still fits
    // in W bits when the result is read as unsigned.
    assign w_absA       = A[W-1] ? -A : A;
    assign w_absB       = B[W-1] ? -B : B;
    assign w_loadMcand  = w_absA;
    assign w_loadMplier = X ? w_absB : w_absA;
    assign w_loadNeg    = X & (A[W-1] ^ B[W-1]);
`else
    assign w_loadMcand  = A;
    assign w_loadMplier = X ? B : A;
`endif

    // The partial product is formed at the full 2W width, so the sum cannot overflow.
    assign w_shifted = {{W{1'b0}}, r_mcand} << r_count;
    assign w_accNext = r_mplier[0] ? (r_acc + w_shifted) : r_acc;

`ifdef GPCA_MUL_SIGNED_EN
    assign w_result = r_neg ? -w_accNext : w_accNext;
`else
    assign w_result = w_accNext;
`endif

    assign in_ready  = (r_state == IDLE);
    assign busy      = (r_state == RUN);
    assign out_valid = (r_state == DONE);
    assign S         = r_S;

    // State register. Reset abandons any operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN always takes W edges and never exits early on a zero multiplier.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (in_valid)   w_nextState = RUN;
            RUN:  if (w_lastStep) w_nextState = DONE;
            DONE: if (out_ready)  w_nextState = IDLE;
            default:              w_nextState = IDLE;
        endcase
    end

    // Datapath: load the operands at accept and do one shift-add step per RUN edge.
    // S is updated only on the final step, so no partial result is ever visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_S      <= '0;
`ifdef GPCA_MUL_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_mcand  <= w_loadMcand;
            r_mplier <= w_loadMplier;
            r_acc    <= '0;
            r_count  <= '0;
`ifdef GPCA_MUL_SIGNED_EN
            r_neg    <= w_loadNeg;
`endif
        end else if (r_state == RUN) begin
            r_acc    <= w_accNext;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
            if (w_lastStep) begin
                r_S <= w_result;
            end
        end
    end

endmodule

// File: tb/tb_gpca_mul_seq.sv
// Testbench for gpca_mul_seq (W=9). It runs table vectors, hand-written handshake
// and reset sequences, and randomized operations checked against an arithmetic model.
module tb_gpca_mul_seq;

    localparam int W = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             X = 1'b0;
    logic [W-1:0]     A = '0;
    logic [W-1:0]     B = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2*W-1:0]   S;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic          x;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [2*W-1:0] expS;
    } vec_t;

    gpca_mul_seq #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .X         (X),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Reference product computed with plain integer arithmetic.
    function automatic logic [2*W-1:0] refMul(input logic x, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        longint va;
        longint vb;
        longint p;
        logic [63:0] bits;
        va = longint'(a);
        vb = x ? longint'(b) : longint'(a);
`ifdef GPCA_MUL_SIGNED_EN
        if (a[W-1]) va = va - (longint'(1) << W);
        if (x && b[W-1]) vb = vb - (longint'(1) << W);
        if (!x) vb = va;
`endif
        p = va * vb;
        bits = 64'(p);
        return bits[2*W-1:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic x, input logic [W-1:0] a, input logic [W-1:0] b);
        X = x;
        A = a;
        B = b;
        in_valid = 1'b1;
    endtask

    // Waits for in_ready, lets the accepting edge pass, drops in_valid and scrambles the operands.
    task automatic acceptOp(input string name);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({name, " ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        X = 1'($urandom);
        A = W'($urandom);
        B = W'($urandom);
    endtask

    // Counts edges until out_valid rises and checks the latency, busy, and the result.
    task automatic waitResult(input string name, input logic [2*W-1:0] expS);
        int lat = 0;
        int busyBad = 0;
        while (!out_valid && lat < 30) begin
            if (!busy) busyBad++;
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, " latency"}, 32'(lat), 32'(W));
        checkOutput({name, " busy"}, 32'(busyBad), 32'd0);
        checkOutput({name, " S"}, 32'(S), 32'(expS));
    endtask

    // Holds backpressure for the given number of cycles, then releases the result.
    task automatic holdAndRelease(input string name, input logic [2*W-1:0] expS, input int hold);
        int bad = 0;
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!out_valid || S !== expS || in_ready) bad++;
        end
        if (hold > 0) checkOutput({name, " hold"}, 32'(bad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, " release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    task automatic runOp(input string name, input logic x, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [2*W-1:0] expS,
                         input int hold, input logic earlyReady);
        applyStimulus(x, a, b);
        out_ready = earlyReady;
        acceptOp(name);
        waitResult(name, expS);
        holdAndRelease(name, expS, hold);
    endtask

    initial begin
        vec_t vecs[$];
        logic rx;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int holdBad;

`ifdef GPCA_MUL_SIGNED_EN
        vecs.push_back('{1'b1, 9'h1FD, 9'h005, 18'h3FFF1});
        vecs.push_back('{1'b1, 9'h100, 9'h100, 18'h10000});
        vecs.push_back('{1'b0, 9'h1FB, 9'h0AB, 18'h00019});
        vecs.push_back('{1'b1, 9'h1FF, 9'h1FF, 18'h00001});
        vecs.push_back('{1'b0, 9'h00D, 9'h1FF, 18'h000A9});
`else
        vecs.push_back('{1'b1, 9'h1FF, 9'h1FF, 18'h3FC01});
        vecs.push_back('{1'b0, 9'h00D, 9'h1FF, 18'h000A9});
        vecs.push_back('{1'b1, 9'h000, 9'h155, 18'h00000});
        vecs.push_back('{1'b1, 9'h1FF, 9'h001, 18'h001FF});
        vecs.push_back('{1'b1, 9'h100, 9'h002, 18'h00200});
`endif

        rst = 1'b1;
        #12;
        checkOutput("reset S", 32'(S), 32'd0);
        checkOutput("reset flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            runOp($sformatf("vec%0d", i), vecs[i].x, vecs[i].a, vecs[i].b, vecs[i].expS, 0, 1'b0);
        end

        // Backpressure on 6*7, with the next request (25*4) held valid the whole time.
        applyStimulus(1'b1, 9'd6, 9'd7);
        acceptOp("bp");
        waitResult("bp", refMul(1'b1, 9'd6, 9'd7));
        applyStimulus(1'b1, 9'd25, 9'd4);
        holdBad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (!out_valid || S !== 18'd42 || in_ready) holdBad++;
        end
        checkOutput("bp hold", 32'(holdBad), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput("b2b release", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(posedge clk); #1;
        checkOutput("b2b accepted", {29'd0, out_valid, busy, in_ready}, 32'b010);
        in_valid = 1'b0;
        waitResult("b2b", 18'd100);
        holdAndRelease("b2b", 18'd100, 0);

        // Zero operand, with a new request pulsed in mid-RUN that must be ignored.
        applyStimulus(1'b1, 9'd0, 9'h155);
        acceptOp("zero");
        @(posedge clk); #1;
        @(posedge clk); #1;
        applyStimulus(1'b1, 9'h1FF, 9'h1FF);
        begin
            int lat = 2;
            while (!out_valid && lat < 30) begin
                @(posedge clk); #1;
                lat++;
            end
            checkOutput("zero latency", 32'(lat), 32'(W));
        end
        in_valid = 1'b0;
        checkOutput("zero S", 32'(S), 32'd0);
        holdAndRelease("zero", 18'd0, 2);

        // Produce a nonzero S, then reset in the middle of the next operation.
        runOp("pre", 1'b1, 9'd11, 9'd13, refMul(1'b1, 9'd11, 9'd13), 0, 1'b0);
        applyStimulus(1'b1, 9'd100, 9'd200);
        acceptOp("rst");
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        checkOutput("midrst S", 32'(S), 32'd0);
        checkOutput("midrst flags", {29'd0, out_valid, busy, in_ready}, 32'b001);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        runOp("post", 1'b1, 9'd3, 9'd3, 18'd9, 0, 1'b0);

        // Random operations against the model, including out_ready held high during RUN.
        for (int i = 0; i < 25; i++) begin
            rx = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 7 == 0) ra = '0;
            if (i % 5 == 0) rb = '1;
            runOp($sformatf("rnd%0d", i), rx, ra, rb, refMul(rx, ra, rb),
                  int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
